// File: rtl/switch_pkg.sv
// Shared switch-path constants and vector type, common to the debouncer and
// the downstream switch_driver integration.
package switch_pkg;

  localparam int SW_N_CH_DEFAULT     = 2;
  localparam int SW_DEBOUNCE_DEFAULT = 1000;

  typedef logic [SW_N_CH_DEFAULT-1:0] sw_vec_t;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchroniser for an asynchronous input.
// Both stages clear to 0 on reset.
module sync_2ff (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic sync1_reg;
  logic sync2_reg;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
    end else begin
      sync1_reg <= i_d;
      sync2_reg <= sync1_reg;
    end
  end

  assign o_q = sync2_reg;

endmodule

// File: rtl/switch_debouncer.sv
// Per-channel synchroniser + stability-counter debouncer for raw switch inputs.
// Define SWITCH_DEBOUNCER_EDGE_EN to build the o_rise/o_fall pulse registers.
module switch_debouncer
  import switch_pkg::*;
#(
  parameter int N_CH            = SW_N_CH_DEFAULT,
  parameter int DEBOUNCE_CYCLES = SW_DEBOUNCE_DEFAULT
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [N_CH-1:0] i_sw_raw,
  output logic [N_CH-1:0] o_sw_clean,
  output logic [N_CH-1:0] o_rise,
  output logic [N_CH-1:0] o_fall
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [N_CH-1:0] sync2;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    logic          clean_reg;
    logic [CW-1:0] cnt_reg;
    logic          accept;

    sync_2ff u_sync (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_d     (i_sw_raw[gi]),
      .o_q     (sync2[gi])
    );

    // A new level is taken only after D consecutive mismatching samples.
    assign accept = (sync2[gi] != clean_reg) && (cnt_reg == CNT_LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        clean_reg <= 1'b0;
        cnt_reg   <= '0;
      end else if (sync2[gi] == clean_reg) begin
        cnt_reg <= '0;
      end else if (accept) begin
        clean_reg <= sync2[gi];
        cnt_reg   <= '0;
      end else begin
        cnt_reg <= cnt_reg + CW'(1);
      end
    end

    assign o_sw_clean[gi] = clean_reg;

`ifdef SWITCH_DEBOUNCER_EDGE_EN
    logic rise_reg;
    logic fall_reg;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        rise_reg <= 1'b0;
        fall_reg <= 1'b0;
      end else begin
        rise_reg <= accept &&  sync2[gi];
        fall_reg <= accept && !sync2[gi];
      end
    end

    assign o_rise[gi] = rise_reg;
    assign o_fall[gi] = fall_reg;
`endif
  end

`ifndef SWITCH_DEBOUNCER_EDGE_EN
  assign o_rise = '0;
  assign o_fall = '0;
`endif

endmodule

// File: doc/switch_debouncer.md
# switch_debouncer

Per-channel synchroniser and debouncer for raw mechanical switch inputs. It sits directly upstream of `switch_driver` and feeds that block's `i_data`. Each channel goes through a 2-flop synchroniser and then a stability counter, so only clean, glitch-free levels reach the summing stage. Optional one-cycle rise/fall pulses are available for event-driven consumers.

## Interface
- `N_CH`, default 2: number of independent switch channels; must be ≥1.
- `DEBOUNCE_CYCLES`, default 1000: consecutive stable synchronised cycles required before a level is accepted; must be ≥1.
- `i_clk`  in  1: single clock for all logic.
- `i_rst_n`  in  1: one clock; reset is asynchronous and active-low.
- `i_sw_raw`  in  N_CH: asynchronous raw switch levels.
- `o_sw_clean`  out  N_CH: debounced level, registered; connects to `switch_driver.i_data`.
- `o_rise`  out  N_CH: one-cycle pulse on accepted 0→1 transition, registered.
- `o_fall`  out  N_CH: one-cycle pulse on accepted 1→0 transition, registered.

## Operation
- **Synchroniser.** Each channel: `i_sw_raw[c]` → `sync1[c]` → `sync2[c]`. Both flops reset to 0.
- **Counter.** Each channel has a counter `cnt[c]` of width `$clog2(DEBOUNCE_CYCLES+1)`, reset 0.
- **Per-channel rule, each edge, no reset:**
  - `sync2[c] == o_sw_clean[c]`: `cnt[c]` ← 0. A glitch shorter than D cycles is discarded.
  - Mismatch and `cnt[c] < D-1`: `cnt[c]` ← `cnt[c]+1`.
  - Mismatch and `cnt[c] == D-1`: `o_sw_clean[c]` ← `sync2[c]` and `cnt[c]` ← 0.
- **Edge pulses.** They are set on the same edge that updates `o_sw_clean[c]`:
  - `o_rise[c]` ← 1 if the new value is 1.
  - `o_fall[c]` ← 1 if the new value is 0.
  - On every other edge both pulses ← 0.
  - `o_rise[c]` and `o_fall[c]` are never high together.
- **Channel independence.** Channels are fully independent; simultaneous transitions on several channels are each handled on their own.
- **Counter range.** The counter never exceeds D-1 and has no wrap-around.
- **Reset values.** `o_sw_clean`=0, `o_rise`=0, `o_fall`=0, all `cnt`=0, all sync flops 0.
- **Reset mid-count.** A reset during a count discards the partial count. After release, a sustained high input is re-qualified from zero and produces a fresh `o_rise`.

## Timing
- **Latency.** If the raw level changes and is first sampled into `sync1` on edge 0, and stays stable, then `o_sw_clean` changes on edge D+1. `o_rise`/`o_fall` is high for exactly the cycle following edge D+1.
- **D=1.** Latency is 2 edges, i.e. synchroniser only plus one qualification edge.
- **Bounce.** Any mismatch-free cycle at `sync2` during qualification restarts the count. Acceptance therefore requires D consecutive mismatching `sync2` samples.
- **Downstream.** `switch_driver` adds one more register, so raw-to-sum latency is D+2 edges.
- **No combinational paths.** There is no combinational path from any input to any output.

## Configuration
- Macro: `SWITCH_DEBOUNCER_EDGE_EN`.
- **Defined:** the `o_rise`/`o_fall` pulse registers are built as described above.
- **Undefined:**
  - `o_rise` and `o_fall` are tied to constant 0 and no pulse registers are built.
  - `o_sw_clean` behaviour and latency are unchanged.
  - The port list is identical in both builds.

## Structure
- **Shared package `switch_pkg`:**
  - Constants `SW_N_CH_DEFAULT = 2` and `SW_DEBOUNCE_DEFAULT = 1000`.
  - Typedef `sw_vec_t` as `logic [SW_N_CH_DEFAULT-1:0]`, shared with `switch_driver` integration.
- **Sub-module `sync_2ff`:** a single-bit 2-flop synchroniser with async active-low reset to 0, instantiated once per channel.
- **Top level:** the counter/qualification logic lives in the top-level generate loop.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 and `N_CH`=2, with the macro defined unless stated otherwise.
- **Reset values.** Assert `i_rst_n`=0 with `i_sw_raw`=2'b11 → `o_sw_clean`=2'b00 and `o_rise`=`o_fall`=2'b00 throughout reset.
- **Clean rise.** Step `i_sw_raw[0]` 0→1, first sampled on edge 0, held → `o_sw_clean`=2'b01 after edge 5, `o_rise`=2'b01 for exactly that one cycle, `o_fall`=0.
- **Bounce rejection.** `i_sw_raw[1]` toggles high 3 cycles, low 1 cycle, high 3 cycles, then low → `o_sw_clean[1]` stays 0 and no pulses occur.
- **Fall and simultaneous channels.**
  - From `o_sw_clean`=2'b11, drive `i_sw_raw`=2'b00 on one edge → both bits clear on the same edge and `o_fall`=2'b11 for one cycle.
  - Driving `switch_driver` with this output, its `o_data` steps 2→0 one edge later.
- **Reset mid-count.** Raise `i_sw_raw[0]`, assert reset after 3 qualifying edges, release and hold high → `o_sw_clean[0]` rises D+1 edges after the first post-reset sample, with a single `o_rise`.
- **Macro undefined.** Repeat the clean-rise scenario → `o_sw_clean` timing is identical, and `o_rise` and `o_fall` stay 0 for the whole run.
